frame_max_tracker: RTL and testbench
====================================

// Module: frame_max_tracker
// PURPOSE
//  Sequential stage directly downstream of the 8-bit unsigned greater-than comparator.
//  Drives the comparator inputs:
//    cmp_a = incoming sample
//    cmp_b = running maximum
//  Consumes the comparator's all-ones/all-zeros mask, and tracks the maximum and its
//  index over a frame of FRAME_LEN samples. Presents {max, idx} on a valid/ready
//  output port.
// PARAMETERS
//  WIDTH      8  sample width; must match the comparator width
//  FRAME_LEN  8  samples per frame; legal range 1..256
//  IDX_W      3  index width; IDX_W = clog2(FRAME_LEN), minimum 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block accepts a sample this cycle
//  in_data    in   WIDTH  unsigned sample
//  cmp_a      out  WIDTH  to comparator A; combinational copy of in_data
//  cmp_b      out  WIDTH  to comparator B; registered running max
//  gt_mask    in   WIDTH  from comparator Y; all-ones means A > B
//  out_valid  out  1      frame result valid
//  out_ready  in   1      consumer takes the result
//  out_max    out  WIDTH  frame maximum
//  out_idx    out  IDX_W  position in the frame of the first occurrence of the maximum
//  mask_err   out  1      sticky flag: gt_mask was not uniform on an accepted sample
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs and registers are 0, and the FSM goes to S_FIRST.
//    Assertion in mid-frame discards the partial frame.
//    After release, the first accepted sample is index 0 of a new frame.
//  Handshake: a sample is accepted when in_valid & in_ready, sampled at the clk edge.
//    The result is taken when out_valid & out_ready.
//  Compare: gt = gt_mask[WIDTH-1], and is used in the same cycle as the accept.
//    The comparator path is purely combinational; no extra latency.
//    Comparison is strict, so ties keep the earlier index.
//  FSM:
//   S_FIRST  in_ready=1, out_valid=0.
//            On accept: max<=in_data, idx<=0, cnt<=1.
//            Goes to S_OUT if FRAME_LEN==1, else to S_ACC.
//            gt_mask is ignored here and not checked for mask_err.
//   S_ACC    in_ready=1, out_valid=0.
//            On accept: if gt, then max<=in_data and idx<=cnt.
//            cnt<=cnt+1.
//            If cnt==FRAME_LEN-1, go to S_OUT.
//            If in_valid=0, hold all state; gaps are allowed.
//   S_OUT    in_ready=0, out_valid=1, out_max=max, out_idx=idx.
//            Outputs are stable until taken.
//            On out_ready: go to S_FIRST and clear cnt.
//            max/idx keep their last values; out_max/out_idx are only meaningful
//            while out_valid=1.
//  Latency: out_valid rises on the clk edge that accepts sample FRAME_LEN-1,
//    i.e. it is visible one cycle after the last sample handshake.
//    Back-to-back frames therefore lose exactly one input cycle (the S_OUT cycle)
//    when out_ready is held at 1.
//  cnt: IDX_W+1 bits wide, so FRAME_LEN=2^IDX_W cannot overflow the compare.
//    idx takes the low IDX_W bits.
//  mask_err: set on an S_ACC accept when gt_mask is neither all-0 nor all-1.
//    Cleared only by rst_n. Tracking continues using the MSB of gt_mask.
//  cmp_b = max register: 0 after reset, otherwise the running max.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1
//    -> in_ready=0, out_valid=0, out_max=0, mask_err=0.
//    Release -> in_ready=1 on the next cycle.
//  2 Frame 03,7F,10,7F,00,FF,FE,01, out_ready=1
//    -> out_valid one cycle after the 8th accept, out_max=FF, out_idx=5.
//  3 Ties: frame of all 5A
//    -> out_max=5A, out_idx=0.
//    Frame 00,..,00,80 (80 at index 7)
//    -> out_max=80, out_idx=7.
//  4 Backpressure: out_ready=0 for 10 cycles while in_valid=1
//    -> in_ready=0, outputs stable, no sample lost.
//    Then out_ready=1 -> the next frame starts at idx 0.
//  5 Reset mid-frame after 4 samples (values 20,40,60,80), then frame 11..18
//    -> out_max=18, out_idx=7; no residue from the old frame.
//  6 Force gt_mask=0F on one S_ACC accept
//    -> mask_err=1 and stays 1 across frames until rst_n.
//    Run with the real comparator in a scoreboard against a reference max model,
//    500 random frames with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/frame_max_tracker.sv
// Per-frame maximum tracker that sits downstream of an external greater-than comparator.
// It reports the frame maximum and the index of its first occurrence on a valid/ready port.
module frame_max_tracker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic [WIDTH-1:0] gt_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             mask_err
);

    // state   | meaning
    // S_FIRST | waiting for sample 0 of a frame; loads max unconditionally
    // S_ACC   | accumulating samples 1..FRAME_LEN-1
    // S_OUT   | result presented; input stalled until the result is taken
    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam int unsigned    LAST_I   = FRAME_LEN - 1;
    localparam logic [IDX_W:0] CNT_LAST = LAST_I[IDX_W:0];
    localparam logic [IDX_W:0] CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               en_q;

    logic               accept;
    logic               take;
    logic               gt;
    logic               mask_uniform;

    assign gt           = gt_mask[WIDTH-1];
    assign mask_uniform = (gt_mask == '0) || (gt_mask == '1);
    assign accept       = in_valid && in_ready;
    assign take         = out_valid && out_ready;

    // en_q keeps in_ready low during reset and for the cycle in which reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FIRST;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    state_d = (FRAME_LEN == 1) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (accept && (cnt_q == CNT_LAST)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (take) begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    max_d = in_data;
                    idx_d = '0;
                    cnt_d = CNT_ONE;
                end
            end
            S_ACC: begin
                if (accept) begin
                    // Strict compare: a tie leaves the earlier index in place.
                    if (gt) begin
                        max_d = in_data;
                        idx_d = cnt_q[IDX_W-1:0];
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (!mask_uniform) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (take) begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_FIRST: in_ready  = en_q;
            S_ACC:   in_ready  = en_q;
            S_OUT:   out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign cmp_a    = in_data;
    assign cmp_b    = max_q;
    assign out_max  = max_q;
    assign out_idx  = idx_q;
    assign mask_err = err_q;

endmodule

// File: tb/tb_frame_max_tracker.sv
// Directed and random bench for frame_max_tracker, with a behavioural comparator
// driving gt_mask and an optional override to inject non-uniform masks.
module tb_frame_max_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    logic       in_ready;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;
    logic [7:0] gt_mask;
    logic       out_valid;
    logic [7:0] out_max;
    logic [2:0] out_idx;
    logic       mask_err;

    int total = 0;
    int passed = 0;
    int fails = 0;

    frame_max_tracker #(.WIDTH(8), .FRAME_LEN(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .gt_mask   (gt_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .mask_err  (mask_err)
    );

    always #5 clk = ~clk;

    assign gt_mask = force_en ? force_val : ((cmp_a > cmp_b) ? 8'hFF : 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [7:0] v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [7:0] emax, input logic [2:0] eidx);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_max"}, {24'd0, out_max}, {24'd0, emax});
        chk({tag, "_idx"}, {29'd0, out_idx}, {29'd0, eidx});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] f [8],
                             input logic [7:0] emax, input logic [2:0] eidx);
        for (int i = 0; i < 8; i++) send(f[i]);
        take_result(tag, emax, eidx);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] fr [8];
        logic [7:0] m;
        logic [7:0] v;
        logic [2:0] mi;

        // Reset with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_max", {24'd0, out_max}, 32'd0);
        chk("rst_mask_err", {31'd0, mask_err}, 32'd0);
        chk("rst_cmp_b", {24'd0, cmp_b}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("rel_in_ready_same", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready_next", {31'd0, in_ready}, 32'd1);

        // Mixed frame, latency check
        fr = '{8'h03, 8'h7F, 8'h10, 8'h7F, 8'h00, 8'hFF, 8'hFE, 8'h01};
        for (int i = 0; i < 7; i++) send(fr[i]);
        chk("t2_not_yet_valid", {31'd0, out_valid}, 32'd0);
        chk("t2_cmp_b_running", {24'd0, cmp_b}, 32'h0FF);
        send(fr[7]);
        take_result("t2", 8'hFF, 3'd5);

        // Ties
        fr = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        run_frame("t3_ties", fr, 8'h5A, 3'd0);
        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        run_frame("t3_last", fr, 8'h80, 3'd7);

        // Backpressure
        fr = '{8'h11, 8'h99, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        for (int i = 0; i < 8; i++) send(fr[i]);
        in_valid = 1'b1;
        in_data  = 8'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("t4_out_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("t4_out_max_hold", {24'd0, out_max}, 32'h99);
            chk("t4_out_idx_hold", {29'd0, out_idx}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t4_in_ready_back", {31'd0, in_ready}, 32'd1);
        send(8'h33);
        for (int i = 1; i < 8; i++) send(8'(i));
        take_result("t4_next", 8'h33, 3'd0);

        // Reset mid-frame
        send(8'h20); send(8'h40); send(8'h60); send(8'h80);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_cmp_b", {24'd0, cmp_b}, 32'd0);
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        fr = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        run_frame("t5", fr, 8'h18, 3'd7);

        // Non-uniform mask on the first sample is not checked
        force_en = 1'b1; force_val = 8'h0F;
        send(8'h10);
        force_en = 1'b0;
        for (int i = 1; i < 8; i++) send(8'h01);
        chk("t6_first_ignored", {31'd0, mask_err}, 32'd0);
        take_result("t6a", 8'h10, 3'd0);

        // Non-uniform mask in S_ACC: MSB=0 so 30 is not taken as max
        send(8'h10); send(8'h20);
        force_en = 1'b1; force_val = 8'h0F;
        send(8'h30);
        force_en = 1'b0;
        chk("t6_err_set", {31'd0, mask_err}, 32'd1);
        send(8'h05); send(8'h06); send(8'h07); send(8'h08); send(8'h09);
        take_result("t6b", 8'h20, 3'd1);
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame("t6c", fr, 8'h08, 3'd7);
        chk("t6_err_sticky", {31'd0, mask_err}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_err_cleared", {31'd0, mask_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Random frames against a reference max model
        for (int f = 0; f < 500; f++) begin
            m = 8'h00;
            mi = 3'd0;
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                v = ($urandom_range(0, 3) == 0) ? 8'hC0 : 8'($urandom_range(0, 255));
                if (i == 0 || v > m) begin
                    m  = v;
                    mi = 3'(i);
                end
                send(v);
                chk("rnd_cmp_b", {24'd0, cmp_b}, {24'd0, m});
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take_result("rnd", m, mi);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
